id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline register for the 5-stage RV32I core. It captures the decoded instruction, its immediate and the two operands read asynchronously from the register file. It resolves the same-cycle writeback/read hazard by bypassing the writeback value, and forces x0 reads to zero. It also detects load-use hazards, inserting a bubble and raising a stall toward IF/ID and the PC, and it accepts flushes from branch resolution.

## Interface
- XLEN, 32: datapath width.
- CTRL_W, 16: width of the control bundle; field indices come from the shared package.
- CLK  in  1: clock; all state updates on posedge.
- RESET  in  1: synchronous, active-high.
- PC_IN  in  XLEN: PC of the decoding instruction.
- IMM_IN  in  XLEN: sign-extended immediate.
- RS1_ADDR, RS2_ADDR  in  5 each: source register indices; the same indices drive the register file read addresses.
- RS1_USED, RS2_USED  in  1 each: the instruction actually reads rs1 / rs2.
- RD_ADDR  in  5: destination register index.
- REG1_DATA, REG2_DATA  in  XLEN: register file read outputs.
- CTRL_IN  in  CTRL_W: decoded control bundle.
- VALID_IN  in  1: the IF/ID slot holds a real instruction.
- WB_WRITE  in  1: writeback enable; same net as the register file write enable.
- WB_ADDR  in  5: writeback index.
- WB_DATA  in  XLEN: writeback value.
- FLUSH  in  1: branch/jump taken in EX; kill the ID-stage instruction.
- LOAD_USE_STALL  out  1: combinational; hold PC and IF/ID this cycle.
- PC_OUT, IMM_OUT, DATA1_OUT, DATA2_OUT  out  XLEN: registered values to EX.
- RS1_OUT, RS2_OUT, RD_OUT  out  5 each: registered indices for the EX forwarding unit.
- CTRL_OUT  out  CTRL_W: registered control bundle.
- VALID_OUT  out  1: registered valid.
- BUBBLE_COUNT  out  16: saturating count of inserted bubbles (stall plus flush).

## Operation
- Operand select, per source, highest priority first:
  - address 0 → 0, regardless of register file contents. The register file does not protect x0.
  - WB_WRITE & WB_ADDR==RSx_ADDR → WB_DATA. This is the bypass.
  - otherwise → REGx_DATA.
- Load-use hazard: VALID_OUT & CTRL_OUT[CTRL_MEMREAD] & RD_OUT≠0 & ((RS1_USED & RS1_ADDR==RD_OUT) | (RS2_USED & RS2_ADDR==RD_OUT)) & VALID_IN.
- LOAD_USE_STALL equals the hazard term ANDed with !FLUSH.
- Per posedge, priority order:
  - RESET → all outputs 0, BUBBLE_COUNT 0.
  - FLUSH → bubble.
  - hazard → bubble.
  - else → capture all inputs, VALID_OUT ← VALID_IN.
- Bubble: VALID_OUT 0, CTRL_OUT all zero, RD_OUT 0, data and index outputs 0.
- BUBBLE_COUNT increments on every bubble and saturates at 0xFFFF.
- A stall lasts exactly one cycle. The bubble carries no MEMREAD, so the re-presented instruction captures on the next edge. Its operand then comes from the EX forwarding path, or from the WB bypass two cycles later.

## Timing
- Latency is one cycle from ID inputs to registered outputs.
- LOAD_USE_STALL is valid in the same cycle as the hazard and depends only on registered state plus ID inputs.
- REGx_DATA arrives with the register file read delay, which must settle well inside the cycle. The stage samples only at posedge.
- The register file commits its write after the edge. In the cycle of a writeback, REGx_DATA is stale, so the bypass is mandatory.
- Simultaneous FLUSH and hazard: flush wins, LOAD_USE_STALL is 0 and the wrong-path instruction is dropped.
- RESET asserted mid-stall: outputs clear on that edge, LOAD_USE_STALL falls because VALID_OUT becomes 0, and BUBBLE_COUNT is not incremented.
- An invalid ID slot (VALID_IN 0) never raises a stall.

## Structure
- Shared package `rv_pipe_pkg`:
  - CTRL_W.
  - Control field indices: CTRL_REGWRITE=0, CTRL_MEMREAD=1, CTRL_MEMWRITE=2, CTRL_BRANCH=3, CTRL_JUMP=4, CTRL_ALUOP[9:5], CTRL_ALUSRC=10, CTRL_WBSEL[12:11].
  - The CTRL_BUBBLE constant, all zeros.
- One sub-module, `operand_bypass`, instantiated twice. It takes an address, register data and the WB signals, and produces the selected operand.
- Hazard logic and the pipeline register stay in the top module.

## Test plan
- Reset then idle: after RESET, all outputs are 0. With VALID_IN 0 for 5 cycles, VALID_OUT stays 0 and BUBBLE_COUNT stays 0.
- WB bypass: set REG1_DATA=0x11, WB_WRITE=1, WB_ADDR=RS1_ADDR=5, WB_DATA=0xDEADBEEF. Next cycle DATA1_OUT=0xDEADBEEF.
- x0: set RS2_ADDR=0, REG2_DATA=0x1234, and WB writing x0 with 0xFF. Next cycle DATA2_OUT=0.
- Load-use: lw x7 is in EX and add x8,x7,x1 is in ID. LOAD_USE_STALL=1 for one cycle and the next VALID_OUT=0 with CTRL_OUT=0. The following cycle captures the add with RS1_OUT=7, and BUBBLE_COUNT=1.
- Flush plus hazard: raise FLUSH during the above hazard. LOAD_USE_STALL=0, a bubble is inserted, and BUBBLE_COUNT increments by 1 only.
- Saturation: force 65,540 bubbles. BUBBLE_COUNT holds 0xFFFF.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: control bundle width,
// control field positions and the all-zero bubble control word.
package rv_pipe_pkg;

    localparam int CTRL_W = 16;

    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMREAD   = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_JUMP      = 4;
    localparam int CTRL_ALUOP_LSB = 5;
    localparam int CTRL_ALUOP_MSB = 9;
    localparam int CTRL_ALUSRC    = 10;
    localparam int CTRL_WBSEL_LSB = 11;
    localparam int CTRL_WBSEL_MSB = 12;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/operand_bypass.sv
// Selects one source operand: x0 reads as zero, a same-cycle writeback to the
// source register is bypassed, otherwise the register file value is used.
module operand_bypass #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            wb_write,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] operand
);

    // The register file commits after the edge, so reg_data is stale while a
    // write to the same index is in flight; x0 is not protected by the file.
    always_comb begin
        operand = reg_data;
        if (addr == 5'd0) begin
            operand = '0;
        end else if (wb_write && (wb_addr == addr)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded instruction and bypassed
// operands, inserts bubbles on load-use hazards and branch flushes.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = rv_pipe_pkg::CTRL_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [XLEN-1:0]   PC_IN,
    input  logic [XLEN-1:0]   IMM_IN,
    input  logic [4:0]        RS1_ADDR,
    input  logic [4:0]        RS2_ADDR,
    input  logic              RS1_USED,
    input  logic              RS2_USED,
    input  logic [4:0]        RD_ADDR,
    input  logic [XLEN-1:0]   REG1_DATA,
    input  logic [XLEN-1:0]   REG2_DATA,
    input  logic [CTRL_W-1:0] CTRL_IN,
    input  logic              VALID_IN,
    input  logic              WB_WRITE,
    input  logic [4:0]        WB_ADDR,
    input  logic [XLEN-1:0]   WB_DATA,
    input  logic              FLUSH,
    output logic              LOAD_USE_STALL,
    output logic [XLEN-1:0]   PC_OUT,
    output logic [XLEN-1:0]   IMM_OUT,
    output logic [XLEN-1:0]   DATA1_OUT,
    output logic [XLEN-1:0]   DATA2_OUT,
    output logic [4:0]        RS1_OUT,
    output logic [4:0]        RS2_OUT,
    output logic [4:0]        RD_OUT,
    output logic [CTRL_W-1:0] CTRL_OUT,
    output logic              VALID_OUT,
    output logic [15:0]       BUBBLE_COUNT
);

    import rv_pipe_pkg::CTRL_MEMREAD;
    import rv_pipe_pkg::CTRL_BUBBLE;

    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            hazard;
    logic            bubble;

    operand_bypass #(.XLEN(XLEN)) u_bypass1 (
        .addr     (RS1_ADDR),
        .reg_data (REG1_DATA),
        .wb_write (WB_WRITE),
        .wb_addr  (WB_ADDR),
        .wb_data  (WB_DATA),
        .operand  (operand1)
    );

    operand_bypass #(.XLEN(XLEN)) u_bypass2 (
        .addr     (RS2_ADDR),
        .reg_data (REG2_DATA),
        .wb_write (WB_WRITE),
        .wb_addr  (WB_ADDR),
        .wb_data  (WB_DATA),
        .operand  (operand2)
    );

    // VALID_IN marks a real instruction in ID; VALID_OUT marks a real one in EX.
    // A load in EX whose rd feeds the ID instruction cannot be forwarded in time.
    always_comb begin
        hazard = VALID_OUT && CTRL_OUT[CTRL_MEMREAD] && (RD_OUT != 5'd0) && VALID_IN &&
                 ((RS1_USED && (RS1_ADDR == RD_OUT)) || (RS2_USED && (RS2_ADDR == RD_OUT)));
        bubble = FLUSH || hazard;
        LOAD_USE_STALL = hazard && !FLUSH;
    end

    always_ff @(posedge CLK) begin
        if (RESET || bubble) begin
            PC_OUT    <= '0;
            IMM_OUT   <= '0;
            DATA1_OUT <= '0;
            DATA2_OUT <= '0;
            RS1_OUT   <= '0;
            RS2_OUT   <= '0;
            RD_OUT    <= '0;
            CTRL_OUT  <= CTRL_W'(CTRL_BUBBLE);
            VALID_OUT <= 1'b0;
        end else begin
            PC_OUT    <= PC_IN;
            IMM_OUT   <= IMM_IN;
            DATA1_OUT <= operand1;
            DATA2_OUT <= operand2;
            RS1_OUT   <= RS1_ADDR;
            RS2_OUT   <= RS2_ADDR;
            RD_OUT    <= RD_ADDR;
            CTRL_OUT  <= CTRL_IN;
            VALID_OUT <= VALID_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            BUBBLE_COUNT <= '0;
        end else if (bubble && (BUBBLE_COUNT != 16'hFFFF)) begin
            BUBBLE_COUNT <= BUBBLE_COUNT + 16'd1;
        end
    end

endmodule
